switch_bal_mode: RTL and testbench

//  Parametrised successor of the bolometer interface switch. Routes one of two control-signal sets to the

---
 rtl/bal_pkg.sv | 12 +
 rtl/bal_sync.sv | 28 ++
 rtl/switch_bal_mode.sv | 145 ++++++++++++++
 tb/tb_switch_bal_mode.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bal_pkg.sv
// rtl/bal_pkg.sv - shared types and constants for the balanced-line mode switch
package bal_pkg;

    typedef enum logic {
        BAL_ACTIVE = 1'b0,
        BAL_GUARD  = 1'b1
    } bal_state_t;

    localparam logic BAL_TYPE_MC = 1'b1;
    localparam logic BAL_TYPE_SY = 1'b0;

endpackage

// File: rtl/bal_sync.sv
// rtl/bal_sync.sv - multi-bit flop-chain synchroniser with async active-low reset
module bal_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [STAGES-1:0][W-1:0] r_chain;

    // Shift the asynchronous input through STAGES flops; every stage clears on reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/switch_bal_mode.sv
// rtl/switch_bal_mode.sv - glitch-free MC/SYNC source switch for balanced lines; optional BAL_ERR_LATCH_EN
module switch_bal_mode
    import bal_pkg::*;
#(
    parameter int               N_OUT        = 4,
    parameter int               N_IN         = 3,
    parameter int               SYNC_STAGES  = 2,
    parameter int               GUARD_CYCLES = 16,
    parameter logic [N_OUT-1:0] IDLE_LEVEL   = '0,
    parameter logic             TYPE_RST     = 1'b0,
    parameter int               LINE_IDX     = 1,
    parameter int               ERR_IDX      = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             TYPE_REQ,
    input  logic [N_OUT-1:0] SRC_MC,
    input  logic [N_OUT-1:0] SRC_SY,
    output logic [N_OUT-1:0] BL_OUT,
    input  logic [N_IN-1:0]  BL_IN,
    output logic [N_IN-1:0]  BL_IN_SYNC,
    output logic             LINE1_RISE,
    output logic             TYPE_ACT,
    output logic             SWITCHING
`ifdef BAL_ERR_LATCH_EN
    ,
    input  logic             ERR_CLR,
    output logic             ERR_LATCHED
`endif
);

    localparam int               CNT_W    = $clog2(GUARD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GUARD_CYCLES - 1);

    bal_state_t       r_state;
    bal_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_type_act;
    logic             w_type_act_nxt;
    logic [N_OUT-1:0] r_bl_out;
    logic [N_OUT-1:0] w_bl_out_nxt;
    logic             r_treq_prev;
    logic             w_treq_s;
    logic [N_IN-1:0]  w_bl_in_s;
    logic             r_line_prev;
    logic             r_line_rise;

    bal_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_type (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_d     (TYPE_REQ),
        .o_q     (w_treq_s)
    );

    bal_sync #(.W(N_IN), .STAGES(SYNC_STAGES)) u_sync_bl_in (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_d     (BL_IN),
        .o_q     (w_bl_in_s)
    );

    // FSM, guard counter, connected mode and registered output lines
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= BAL_GUARD;
            r_cnt       <= CNT_LOAD;
            r_type_act  <= TYPE_RST;
            r_bl_out    <= IDLE_LEVEL;
            r_treq_prev <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_type_act  <= w_type_act_nxt;
            r_bl_out    <= w_bl_out_nxt;
            r_treq_prev <= w_treq_s;
        end
    end

    // Next state: leave ACTIVE on a mode mismatch, count out the guard, restart it if the request moves
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_type_act_nxt = r_type_act;
        w_bl_out_nxt   = IDLE_LEVEL;
        case (r_state)
            BAL_ACTIVE: begin
                if (w_treq_s != r_type_act) begin
                    w_state_nxt = BAL_GUARD;
                    w_cnt_nxt   = CNT_LOAD;
                end else begin
                    w_bl_out_nxt = (r_type_act == BAL_TYPE_MC) ? SRC_MC : SRC_SY;
                end
            end
            BAL_GUARD: begin
                if (w_treq_s != r_treq_prev) begin
                    w_cnt_nxt = CNT_LOAD;
                end else if (r_cnt == '0) begin
                    // Connect whatever is requested now, even if it equals the old mode
                    w_type_act_nxt = w_treq_s;
                    w_state_nxt    = BAL_ACTIVE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = BAL_GUARD;
                w_cnt_nxt   = CNT_LOAD;
            end
        endcase
    end

    // Registered rising-edge detector on the synchronised LINE1 return line
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_line_prev <= 1'b0;
            r_line_rise <= 1'b0;
        end else begin
            r_line_prev <= w_bl_in_s[LINE_IDX];
            r_line_rise <= w_bl_in_s[LINE_IDX] & ~r_line_prev;
        end
    end

`ifdef BAL_ERR_LATCH_EN
    logic r_err_latched;

    // Sticky error flag; a set in the same cycle as a clear keeps it set
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_err_latched <= 1'b0;
        end else begin
            r_err_latched <= w_bl_in_s[ERR_IDX] | (r_err_latched & ~ERR_CLR);
        end
    end

    assign ERR_LATCHED = r_err_latched;
`endif

    assign BL_OUT     = r_bl_out;
    assign BL_IN_SYNC = w_bl_in_s;
    assign LINE1_RISE = r_line_rise;
    assign TYPE_ACT   = r_type_act;
    assign SWITCHING  = (r_state == BAL_GUARD);

endmodule

// File: tb/tb_switch_bal_mode.sv
// tb/tb_switch_bal_mode.sv - self-checking bench for switch_bal_mode (optionally with BAL_ERR_LATCH_EN)
module tb_switch_bal_mode;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       TYPE_REQ;
    logic [3:0] SRC_MC;
    logic [3:0] SRC_SY;
    logic [3:0] BL_OUT;
    logic [2:0] BL_IN;
    logic [2:0] BL_IN_SYNC;
    logic       LINE1_RISE;
    logic       TYPE_ACT;
    logic       SWITCHING;
`ifdef BAL_ERR_LATCH_EN
    logic       ERR_CLR;
    logic       ERR_LATCHED;
`endif

    typedef struct {
        logic [3:0] bl_out;
        logic       sw;
    } out_exp_t;

    typedef struct {
        logic sync1;
        logic rise;
    } line_exp_t;

    out_exp_t  out_q[$];
    line_exp_t line_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    switch_bal_mode dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .TYPE_REQ    (TYPE_REQ),
        .SRC_MC      (SRC_MC),
        .SRC_SY      (SRC_SY),
        .BL_OUT      (BL_OUT),
        .BL_IN       (BL_IN),
        .BL_IN_SYNC  (BL_IN_SYNC),
        .LINE1_RISE  (LINE1_RISE),
        .TYPE_ACT    (TYPE_ACT),
        .SWITCHING   (SWITCHING)
`ifdef BAL_ERR_LATCH_EN
        ,
        .ERR_CLR     (ERR_CLR),
        .ERR_LATCHED (ERR_LATCHED)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        out_exp_t e;
        RESET_N  = 1'b0;
        TYPE_REQ = 1'b0;
        SRC_SY   = 4'hA;
        SRC_MC   = 4'h5;
        BL_IN    = 3'b000;
`ifdef BAL_ERR_LATCH_EN
        ERR_CLR  = 1'b0;
`endif
        repeat (3) tick();
        n_checks++; if (BL_OUT !== 4'h0) $display("FAIL rst_bl_out got %h want 0", BL_OUT); else n_pass++;
        n_checks++; if (SWITCHING !== 1'b1) $display("FAIL rst_switching got %b want 1", SWITCHING); else n_pass++;
        n_checks++; if (TYPE_ACT !== 1'b0) $display("FAIL rst_type_act got %b want 0", TYPE_ACT); else n_pass++;
        n_checks++; if (BL_IN_SYNC !== 3'b000) $display("FAIL rst_bl_in_sync got %b want 000", BL_IN_SYNC); else n_pass++;
        n_checks++; if (LINE1_RISE !== 1'b0) $display("FAIL rst_line1_rise got %b want 0", LINE1_RISE); else n_pass++;
`ifdef BAL_ERR_LATCH_EN
        n_checks++; if (ERR_LATCHED !== 1'b0) $display("FAIL rst_err_latched got %b want 0", ERR_LATCHED); else n_pass++;
`endif
        RESET_N = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            e.bl_out = (k <= 16) ? 4'h0 : 4'hA;
            e.sw     = (k <= 15);
            out_q.push_back(e);
        end
        for (int k = 1; k <= 17; k++) begin
            tick();
            e = out_q.pop_front();
            n_checks++; if (BL_OUT !== e.bl_out) $display("FAIL reset_guard_bl_out cyc %0d got %h want %h", k, BL_OUT, e.bl_out); else n_pass++;
            n_checks++; if (SWITCHING !== e.sw) $display("FAIL reset_guard_switching cyc %0d got %b want %b", k, SWITCHING, e.sw); else n_pass++;
        end
    endtask

    task automatic test_switch_to_mc();
        out_exp_t e;
        TYPE_REQ = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            e.bl_out = (k <= 2) ? 4'hA : ((k <= 19) ? 4'h0 : 4'h5);
            e.sw     = (k >= 3) && (k <= 18);
            out_q.push_back(e);
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            e = out_q.pop_front();
            n_checks++; if (BL_OUT !== e.bl_out) $display("FAIL to_mc_bl_out cyc %0d got %h want %h", k, BL_OUT, e.bl_out); else n_pass++;
            n_checks++; if (SWITCHING !== e.sw) $display("FAIL to_mc_switching cyc %0d got %b want %b", k, SWITCHING, e.sw); else n_pass++;
        end
        n_checks++; if (TYPE_ACT !== 1'b1) $display("FAIL to_mc_type_act got %b want 1", TYPE_ACT); else n_pass++;
    endtask

    task automatic test_guard_restart();
        out_exp_t e;
        TYPE_REQ = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            e.bl_out = (k <= 2) ? 4'h5 : ((k <= 24) ? 4'h0 : 4'h5);
            e.sw     = (k >= 3) && (k <= 23);
            out_q.push_back(e);
        end
        for (int k = 1; k <= 25; k++) begin
            tick();
            e = out_q.pop_front();
            n_checks++; if (BL_OUT !== e.bl_out) $display("FAIL restart_bl_out cyc %0d got %h want %h", k, BL_OUT, e.bl_out); else n_pass++;
            n_checks++; if (SWITCHING !== e.sw) $display("FAIL restart_switching cyc %0d got %b want %b", k, SWITCHING, e.sw); else n_pass++;
            if (k == 5) TYPE_REQ = 1'b1;
        end
        n_checks++; if (TYPE_ACT !== 1'b1) $display("FAIL restart_type_act got %b want 1", TYPE_ACT); else n_pass++;
    endtask

    task automatic test_line1_rise();
        line_exp_t e;
        int        n_rise = 0;
        BL_IN = 3'b010;
        for (int k = 1; k <= 16; k++) begin
            e.sync1 = (k >= 2) && (k <= 11);
            e.rise  = (k == 3);
            line_q.push_back(e);
        end
        for (int k = 1; k <= 16; k++) begin
            tick();
            e = line_q.pop_front();
            if (LINE1_RISE === 1'b1) n_rise++;
            n_checks++; if (BL_IN_SYNC[1] !== e.sync1) $display("FAIL line_sync cyc %0d got %b want %b", k, BL_IN_SYNC[1], e.sync1); else n_pass++;
            n_checks++; if (LINE1_RISE !== e.rise) $display("FAIL line_rise cyc %0d got %b want %b", k, LINE1_RISE, e.rise); else n_pass++;
            if (k == 10) BL_IN = 3'b000;
        end
        n_checks++; if (n_rise != 1) $display("FAIL line_rise_count got %0d want 1", n_rise); else n_pass++;
    endtask

    task automatic test_reset_mid_guard();
        out_exp_t e;
        TYPE_REQ = 1'b0;
        repeat (11) tick();
        n_checks++; if (SWITCHING !== 1'b1) $display("FAIL midguard_switching got %b want 1", SWITCHING); else n_pass++;
        n_checks++; if (TYPE_ACT !== 1'b1) $display("FAIL midguard_type_act got %b want 1", TYPE_ACT); else n_pass++;
        #2;
        RESET_N = 1'b0;
        #1;
        n_checks++; if (TYPE_ACT !== 1'b0) $display("FAIL async_rst_type_act got %b want 0", TYPE_ACT); else n_pass++;
        n_checks++; if (BL_OUT !== 4'h0) $display("FAIL async_rst_bl_out got %h want 0", BL_OUT); else n_pass++;
        n_checks++; if (SWITCHING !== 1'b1) $display("FAIL async_rst_switching got %b want 1", SWITCHING); else n_pass++;
        repeat (2) tick();
        RESET_N = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            e.bl_out = (k <= 16) ? 4'h0 : 4'hA;
            e.sw     = (k <= 15);
            out_q.push_back(e);
        end
        for (int k = 1; k <= 17; k++) begin
            tick();
            e = out_q.pop_front();
            n_checks++; if (BL_OUT !== e.bl_out) $display("FAIL rerun_bl_out cyc %0d got %h want %h", k, BL_OUT, e.bl_out); else n_pass++;
            n_checks++; if (SWITCHING !== e.sw) $display("FAIL rerun_switching cyc %0d got %b want %b", k, SWITCHING, e.sw); else n_pass++;
        end
        n_checks++; if (TYPE_ACT !== 1'b0) $display("FAIL rerun_type_act got %b want 0", TYPE_ACT); else n_pass++;
    endtask

`ifdef BAL_ERR_LATCH_EN
    task automatic test_err_latch();
        logic exp_err;
        BL_IN = 3'b100;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) BL_IN = 3'b000;
            exp_err = (k >= 3);
            n_checks++; if (ERR_LATCHED !== exp_err) $display("FAIL err_set cyc %0d got %b want %b", k, ERR_LATCHED, exp_err); else n_pass++;
        end
        BL_IN = 3'b100;
        repeat (3) tick();
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        n_checks++; if (ERR_LATCHED !== 1'b1) $display("FAIL err_set_wins got %b want 1", ERR_LATCHED); else n_pass++;
        BL_IN = 3'b000;
        repeat (3) tick();
        n_checks++; if (ERR_LATCHED !== 1'b1) $display("FAIL err_hold got %b want 1", ERR_LATCHED); else n_pass++;
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        n_checks++; if (ERR_LATCHED !== 1'b0) $display("FAIL err_clear got %b want 0", ERR_LATCHED); else n_pass++;
        tick();
        n_checks++; if (ERR_LATCHED !== 1'b0) $display("FAIL err_stay_clear got %b want 0", ERR_LATCHED); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_switch_to_mc();
        test_guard_restart();
        test_line1_rise();
        test_reset_mid_guard();
`ifdef BAL_ERR_LATCH_EN
        test_err_latch();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
